// File: rtl/ac_sense_scheduler_pkg.sv
// Shared definitions for the AC sense scheduler and the AC-detect filter sizing.
// Detect filters are sized as FILTERBITS = EXC_BITS_DEF + 2.
package ac_sense_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_NEXT   = 2'd3
    } state_t;

    localparam int unsigned EXC_BITS_DEF = 11;

endpackage

// File: rtl/exc_timebase.sv
// Excitation phase counter and completed-period counter for the sense scheduler.
// sq is the excitation level for the clock that follows the current edge.
module exc_timebase
    import ac_sense_scheduler_pkg::*;
#(
    parameter int unsigned EXC_BITS  = EXC_BITS_DEF,
    parameter int unsigned PCNT_BITS = 2
) (
    input  logic                 clk,
    input  logic                 resetq,
    input  logic                 run,
    input  logic                 clr_cnt,
    output logic                 period_end,
    output logic [PCNT_BITS-1:0] pcnt,
    output logic                 sq
);

    logic [EXC_BITS-1:0] phase;
    logic [EXC_BITS-1:0] phase_next;

    always_comb begin
        phase_next = run ? phase + EXC_BITS'(1) : '0;
        period_end = run && (phase == '1);
        sq         = ~phase_next[EXC_BITS-1];
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            phase <= '0;
            pcnt  <= '0;
        end else begin
            phase <= phase_next;
            if (clr_cnt)
                pcnt <= '0;
            else if (period_end)
                pcnt <= pcnt + PCNT_BITS'(1);
        end
    end

endmodule

// File: rtl/ac_sense_scheduler.sv
// Time-multiplexed excitation scheduler: drives one channel at a time, samples
// its detect line, and latches per-channel presence with a sticky change flag.
module ac_sense_scheduler
    import ac_sense_scheduler_pkg::*;
#(
    parameter int unsigned NCH        = 4,
    parameter int unsigned EXC_BITS   = EXC_BITS_DEF,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned SAMPLE_CYC = 2,
    parameter int unsigned CH_BITS    = 2
) (
    input  logic           clk,
    input  logic           resetq,
    input  logic           en,
    input  logic [NCH-1:0] det,
    input  logic           clr,
    output logic [NCH-1:0] exc,
    output logic [NCH-1:0] status,
    output logic           changed,
    output logic           scan_done,
    output logic           busy
);

    localparam int unsigned PCNT_MAX  = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
    localparam int unsigned PCNT_BITS = $clog2(PCNT_MAX + 1);

    state_t               state, state_next;
    logic [CH_BITS-1:0]   ch, ch_next;
    logic                 hit, hit_next;
    logic [NCH-1:0]       status_next, exc_next;
    logic                 changed_next, scan_done_next;
    logic                 det_sel, status_sel;
    logic                 run, clr_cnt, period_end, sq;
    logic [PCNT_BITS-1:0] pcnt;

    exc_timebase #(
        .EXC_BITS  (EXC_BITS),
        .PCNT_BITS (PCNT_BITS)
    ) u_timebase (
        .clk        (clk),
        .resetq     (resetq),
        .run        (run),
        .clr_cnt    (clr_cnt),
        .period_end (period_end),
        .pcnt       (pcnt),
        .sq         (sq)
    );

    always_comb begin
        state_next     = state;
        ch_next        = ch;
        hit_next       = hit;
        status_next    = status;
        changed_next   = clr ? 1'b0 : changed;
        scan_done_next = 1'b0;
        exc_next       = '0;
        det_sel        = 1'b0;
        status_sel     = 1'b0;
        run            = (state == ST_SETTLE) || (state == ST_SAMPLE);

        for (int i = 0; i < NCH; i++) begin
            if (ch == CH_BITS'(i)) begin
                det_sel    = det[i];
                status_sel = status[i];
            end
        end

        // Dropping enable abandons the channel in progress without touching status
        if (state != ST_IDLE && !en) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state_next = ST_SETTLE;
                        ch_next    = '0;
                    end
                end
                ST_SETTLE: begin
                    if (period_end && pcnt == PCNT_BITS'(SETTLE_CYC - 1)) begin
                        state_next = ST_SAMPLE;
                        hit_next   = 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    hit_next = hit & det_sel;
                    if (period_end && pcnt == PCNT_BITS'(SAMPLE_CYC - 1))
                        state_next = ST_NEXT;
                end
                ST_NEXT: begin
                    state_next = ST_SETTLE;
                    for (int i = 0; i < NCH; i++) begin
                        if (ch == CH_BITS'(i))
                            status_next[i] = hit;
                    end
                    if (hit != status_sel)
                        changed_next = 1'b1;
                    if (ch == CH_BITS'(NCH - 1)) begin
                        ch_next        = '0;
                        scan_done_next = 1'b1;
                    end else begin
                        ch_next = ch + CH_BITS'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        clr_cnt = (state_next != state);

        // Drive is computed for the state/phase that will hold after this edge
        if (state_next == ST_SETTLE || state_next == ST_SAMPLE) begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_next == CH_BITS'(i))
                    exc_next[i] = sq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            state     <= ST_IDLE;
            ch        <= '0;
            hit       <= 1'b0;
            status    <= '0;
            changed   <= 1'b0;
            scan_done <= 1'b0;
            busy      <= 1'b0;
            exc       <= '0;
        end else begin
            state     <= state_next;
            ch        <= ch_next;
            hit       <= hit_next;
            status    <= status_next;
            changed   <= changed_next;
            scan_done <= scan_done_next;
            busy      <= (state_next != ST_IDLE);
            exc       <= exc_next;
        end
    end

endmodule

// File: tb/tb_ac_sense_scheduler.sv
// Directed bench for ac_sense_scheduler with NCH=2, EXC_BITS=3, one settle and one sample period.
// Edge numbers below count clock edges since reset release; dwell is 17 clk, scan is 34 clk.
module tb_ac_sense_scheduler;

    localparam int unsigned NCH = 2;

    logic           clk;
    logic           resetq;
    logic           en;
    logic [NCH-1:0] det;
    logic           clr;
    logic [NCH-1:0] exc;
    logic [NCH-1:0] status;
    logic           changed;
    logic           scan_done;
    logic           busy;

    int total;
    int bad;
    int cyc;
    int cnt;

    ac_sense_scheduler #(
        .NCH        (NCH),
        .EXC_BITS   (3),
        .SETTLE_CYC (1),
        .SAMPLE_CYC (1),
        .CH_BITS    (2)
    ) dut (
        .clk       (clk),
        .resetq    (resetq),
        .en        (en),
        .det       (det),
        .clr       (clr),
        .exc       (exc),
        .status    (status),
        .changed   (changed),
        .scan_done (scan_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to 1 time unit after edge n
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    initial begin
        clk = 1'b0; resetq = 1'b0; en = 1'b0; det = '0; clr = 1'b0;
        total = 0; bad = 0; cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_exc", 32'(exc), 0);
        chk_eq("rst_status", 32'(status), 0);
        chk_eq("rst_changed", 32'(changed), 0);
        chk_eq("rst_busy", 32'(busy), 0);
        chk_eq("rst_scan_done", 32'(scan_done), 0);

        resetq = 1'b1; en = 1'b1; cyc = 0;
        goto(1);   chk_eq("ch0_settle_hi", 32'(exc), 1); chk_eq("busy_on", 32'(busy), 1);
        goto(4);   chk_eq("ch0_hi_end", 32'(exc), 1);
        goto(5);   chk_eq("ch0_lo", 32'(exc), 0);
        goto(9);   chk_eq("ch0_sample_hi", 32'(exc), 1);
        goto(17);  chk_eq("ch0_next_exc", 32'(exc), 0); chk_eq("next_busy", 32'(busy), 1);
        goto(18);  chk_eq("ch1_settle_hi", 32'(exc), 2);
        goto(26);  chk_eq("ch1_sample_hi", 32'(exc), 2);
        goto(34);  chk_eq("scan_done_pre", 32'(scan_done), 0);
        goto(35);
        chk_eq("scan_done_1", 32'(scan_done), 1);
        chk_eq("wrap_ch0", 32'(exc), 1);
        chk_eq("scan1_status", 32'(status), 0);
        chk_eq("scan1_changed", 32'(changed), 0);
        cnt = 0;
        for (int t = 36; t <= 68; t++) begin
            goto(t);
            cnt += int'(scan_done);
        end
        chk_eq("scan_done_gap", 32'(cnt), 0);
        goto(69);
        chk_eq("scan_done_2", 32'(scan_done), 1);
        chk_eq("scan2_status", 32'(status), 0);

        // det[1] held high
        det = 2'b10;
        goto(103);
        chk_eq("det1_status", 32'(status), 2);
        chk_eq("det1_changed", 32'(changed), 1);
        clr = 1'b1; goto(104); clr = 1'b0;
        chk_eq("clr_changed", 32'(changed), 0);
        goto(136); chk_eq("steady_changed_pre", 32'(changed), 0);
        goto(137);
        chk_eq("steady_status", 32'(status), 2);
        chk_eq("steady_changed", 32'(changed), 0);

        // one-clk dropout during ch1 sample window
        goto(164); det = 2'b00;
        goto(165); det = 2'b10;
        goto(170); chk_eq("glitch_pre_next", 32'(status), 2);
        goto(171);
        chk_eq("glitch_status", 32'(status), 0);
        chk_eq("glitch_changed", 32'(changed), 1);
        clr = 1'b1; goto(172); clr = 1'b0;
        goto(205);
        chk_eq("recover_status", 32'(status), 2);
        chk_eq("recover_changed", 32'(changed), 1);
        clr = 1'b1; goto(206); clr = 1'b0;
        chk_eq("recover_clr", 32'(changed), 0);

        // dropout confined to ch1 settle window is ignored
        goto(224); det = 2'b00;
        goto(225); det = 2'b10;
        goto(239);
        chk_eq("settle_glitch_status", 32'(status), 2);
        chk_eq("settle_glitch_changed", 32'(changed), 0);

        // enable dropped in ch1 sample window
        goto(266); en = 1'b0;
        goto(267);
        chk_eq("abort_exc", 32'(exc), 0);
        chk_eq("abort_busy", 32'(busy), 0);
        chk_eq("abort_status", 32'(status), 2);
        goto(268); chk_eq("abort_idle", 32'(busy), 0);
        en = 1'b1;
        goto(269);
        chk_eq("restart_ch0", 32'(exc), 1);
        chk_eq("restart_busy", 32'(busy), 1);

        // clr coincident with a status-changing NEXT: set wins
        det = 2'b00;
        goto(302);
        chk_eq("coinc_pre_changed", 32'(changed), 0);
        chk_eq("coinc_pre_status", 32'(status), 2);
        clr = 1'b1; goto(303); clr = 1'b0;
        chk_eq("coinc_status", 32'(status), 0);
        chk_eq("coinc_changed", 32'(changed), 1);
        chk_eq("coinc_scan_done", 32'(scan_done), 1);

        // synchronous reset mid-settle with enable held
        goto(305); resetq = 1'b0;
        goto(306);
        chk_eq("mid_rst_exc", 32'(exc), 0);
        chk_eq("mid_rst_status", 32'(status), 0);
        chk_eq("mid_rst_changed", 32'(changed), 0);
        chk_eq("mid_rst_busy", 32'(busy), 0);
        chk_eq("mid_rst_scan_done", 32'(scan_done), 0);
        resetq = 1'b1;
        goto(307);
        chk_eq("post_rst_ch0", 32'(exc), 1);
        chk_eq("post_rst_busy", 32'(busy), 1);
        goto(311);
        chk_eq("post_rst_lo", 32'(exc), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
